div_unit: RTL and testbench

Iterative radix-2 divider executing the RV32M DIV/DIVU/REM/REMU operations for the execute stage. It sits beside the single-cycle ALU and consumes the same 5-bit `ALUFuncts::Type` code from the issue/decode side, using codes DIV=`10_100`, DIVU=`10_101`, REM=`10_110` and REMU=`10_111`. It produces one 32-bit result per operation to writeback over a valid/ready handshake. The pipeline stalls on `in_ready` and `out_valid`.

---
 rtl/div_unit_if.sv | 28 ++
 rtl/div_unit.sv | 176 +++++++++++++++++
 tb/tb_div_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and div_unit.
//   master (issue side / writeback): drives in_valid, funct, src_a, src_b,
//     flush, out_ready; observes in_ready, out_valid, result.
//   slave (div_unit): the mirror image.
// XLEN sets the operand/result width.
interface div_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      funct;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, funct, src_a, src_b, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, funct, src_a, src_b, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk   : rising-edge clock
//   rst_n : synchronous, active-low reset
//   bus   : div_unit_if.slave
//           in_valid/in_ready  request handshake (in_ready high only in IDLE)
//           funct[1:0]         bit1 = remainder, bit0 = unsigned
//           src_a / src_b      dividend / divisor
//           flush              kills any in-flight operation, wins over handshakes
//           out_valid/out_ready result handshake, result registered and held in DONE
// Build option: define DIV_FAST_SPECIAL_EN to retire divide-by-zero, signed
// overflow and zero-dividend operations straight from IDLE to DONE (latency 1
// instead of 33). Result values do not depend on the option.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic       clk,
    input logic       rst_n,
    div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]   count_q;
    logic [XLEN:0]   rem_q;       // 33-bit partial remainder
    logic [XLEN-1:0] quo_q;       // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0] dvs_q;
    logic            is_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            special_q;
    logic [XLEN-1:0] special_val_q;
    logic [XLEN-1:0] result_q;

    // Only funct[1:0] is decoded; the upper bits are always 10_1xx.
    logic unused_funct;
    assign unused_funct = ^bus.funct[4:2];

    // Request decode.
    logic            accept;
    logic            is_uns, is_rem;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, overflow, special_now, fast_now;
    logic [XLEN-1:0] special_val;

    always_comb begin
        accept   = bus.in_valid && (state_q == IDLE) && !bus.flush;
        is_uns   = bus.funct[0];
        is_rem   = bus.funct[1];
        a_neg    = !is_uns && bus.src_a[XLEN-1];
        b_neg    = !is_uns && bus.src_b[XLEN-1];
        a_abs    = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
        b_abs    = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
        div_zero = (bus.src_b == '0);
        overflow = !is_uns && (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b == '1);
        special_now = div_zero || overflow;

        // Divide-by-zero takes precedence; overflow DIV returns the dividend,
        // which is the most negative value.
        special_val = '0;
        if (div_zero) begin
            special_val = is_rem ? bus.src_a : '1;
        end else if (overflow) begin
            special_val = is_rem ? '0 : bus.src_a;
        end

`ifdef DIV_FAST_SPECIAL_EN
        // A zero dividend with a non-zero divisor yields 0 for every op,
        // which is the default special_val.
        fast_now = special_now || (bus.src_a == '0);
`else
        fast_now = 1'b0;
`endif
    end

    // One restoring step plus the sign fixup used on the final step.
    logic [XLEN:0]   shifted, diff, rem_next;
    logic [XLEN-1:0] quo_next, quo_fix, rem_fix, final_val;
    logic            bit_ok;

    always_comb begin
        shifted   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        diff      = shifted - {1'b0, dvs_q};
        bit_ok    = !diff[XLEN];
        rem_next  = bit_ok ? diff : shifted;
        quo_next  = {quo_q[XLEN-2:0], bit_ok};
        quo_fix   = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
        rem_fix   = neg_rem_q ? (~rem_next[XLEN-1:0] + 1'b1) : rem_next[XLEN-1:0];
        final_val = special_q ? special_val_q : (is_rem_q ? rem_fix : quo_fix);
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (accept) begin
                    state_d = fast_now ? DONE : CALC;
                end
            end
            CALC: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q       <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            is_rem_q      <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            result_q      <= '0;
        end else if (accept) begin
            count_q       <= '1;
            rem_q         <= '0;
            quo_q         <= a_abs;
            dvs_q         <= b_abs;
            is_rem_q      <= is_rem;
            neg_quo_q     <= a_neg ^ b_neg;
            neg_rem_q     <= a_neg;
            special_q     <= special_now;
            special_val_q <= special_val;
            if (fast_now) begin
                result_q <= special_val;
            end
        end else if (state_q == CALC) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (count_q != '0) begin
                count_q <= count_q - 1'b1;
            end else if (!bus.flush) begin
                result_q <= final_val;
            end
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Latency is counted in cycles after the accept edge: 1 means out_valid is
// already high right after the accept edge.
module tb_div_unit;
    localparam int unsigned XLEN = 32;
    localparam logic [4:0] F_DIV  = 5'b10100;
    localparam logic [4:0] F_DIVU = 5'b10101;
    localparam logic [4:0] F_REM  = 5'b10110;
    localparam logic [4:0] F_REMU = 5'b10111;
    localparam int FULL_LAT = 33;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    div_unit_if #(.XLEN(XLEN)) bus ();

    div_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns #1 after the accept edge.
    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.funct    = f;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_idle_ready"}, {31'b0, bus.in_ready}, 32'd1);
        check({tag, "_idle_valid"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        check({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        issue(f, a, b);
        wait_valid(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_result"}, bus.result, exp);
        consume(tag);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check({tag, "_no_valid"}, seen, 32'd0);
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.funct     = F_DIVU;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);

        // Main datapath, full latency.
        run_op("divu_100_7",  F_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);
        run_op("remu_100_7",  F_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT);
        run_op("div_m7_2",    F_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, FULL_LAT);
        run_op("rem_m7_2",    F_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, FULL_LAT);
        run_op("div_20_m6",   F_DIV,  32'd20, 32'hFFFFFFFA, 32'hFFFFFFFD, FULL_LAT);
        run_op("rem_20_m6",   F_REM,  32'd20, 32'hFFFFFFFA, 32'd2, FULL_LAT);
        run_op("divu_big_16", F_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, FULL_LAT);
        run_op("remu_big_16", F_REMU, 32'hFFFFFFFF, 32'h10, 32'hF, FULL_LAT);

        // Special cases.
        run_op("div_5_0",     F_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT);
        run_op("remu_5_0",    F_REMU, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
        run_op("div_ovf",     F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT);
        run_op("rem_ovf",     F_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, SPECIAL_LAT);
        run_op("divu_0_5",    F_DIVU, 32'd0, 32'd5, 32'd0, SPECIAL_LAT);

        // Backpressure: result held for 5 extra cycles, handshake on the 6th.
        issue(F_DIVU, 32'd1000, 32'd10);
        wait_valid(lat);
        check("bp_lat", lat, FULL_LAT);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_result", bus.result, 32'd100);
            check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        consume("bp");

        // Flush during CALC at T+10.
        issue(F_DIVU, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        watch_no_valid("flush", 40);
        run_op("after_flush", F_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);

        // Reset at T+20 of an operation.
        issue(F_DIV, 32'hFFFFFFF9, 32'd2);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_result", bus.result, 32'd0);
        watch_no_valid("midrst", 40);

        // flush together with in_valid in IDLE: no accept.
        bus.flush = 1'b1;
        issue(F_DIV, 32'd5, 32'd0);
        bus.flush = 1'b0;
        check("flush_acc_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("flush_acc_out_valid", {31'b0, bus.out_valid}, 32'd0);
        watch_no_valid("flush_acc", 40);
        run_op("final", F_REM, 32'd20, 32'hFFFFFFFA, 32'd2, FULL_LAT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
